// File: rtl/line_window_3row.sv
`timescale 1ns/1ps
// line_window_3row: streaming 3-row line buffer that emits a vertically aligned
//   column of taps (row r-2, r-1, r) for each accepted raster-order sample.
// Latency: one cycle from input accept to out_valid and output data.
// Backpressure: single output register with no skid buffer. in_ready drops
//   while a column is held unaccepted. Counters and memories freeze while it is held.
//
// Ports:
//   clk, reset (async, active low)
//   in_valid / in_ready / in_sof / in_data     : raster sample input
//   out_valid / out_ready                      : window column handshake
//   out_top / out_mid / out_bot / out_last     : taps r-2 / r-1 / r, last-column flag
//
// Optional feature: define LINE_WINDOW_ZERO_PAD_EN to emit a column for every
// sample. In that mode, taps from rows not yet seen in the frame read as zero.

module line_window_3row #(
  parameter int int_bits   = 20,
  parameter int line_width = 64,
  parameter int col_bits   = $clog2(line_width)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_sof,
  input  logic [int_bits-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [int_bits-1:0] out_top,
  output logic [int_bits-1:0] out_mid,
  output logic [int_bits-1:0] out_bot,
  output logic                out_last
);

  localparam logic [col_bits-1:0] last_col_idx = col_bits'(line_width - 1);

  // Row memories. r1_is_b selects which one holds row r-1; the other holds r-2.
  logic [int_bits-1:0] mem_a [line_width];
  logic [int_bits-1:0] mem_b [line_width];

  logic [col_bits-1:0] col;
  logic [1:0]          rows_seen;
  logic                r1_is_b;

  logic                accept;
  logic [col_bits-1:0] col_eff;
  logic [1:0]          rows_eff;
  logic                r1_is_b_eff;
  logic                at_last_col;
  logic [int_bits-1:0] prev;
  logic [int_bits-1:0] prev2;
  logic                emit;
  logic [int_bits-1:0] top_d;
  logic [int_bits-1:0] mid_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    // A start-of-frame sample sees freshly reset counters and roles, so a
    // partial row from the previous frame is simply abandoned.
    col_eff     = in_sof ? '0    : col;
    rows_eff    = in_sof ? 2'd0  : rows_seen;
    r1_is_b_eff = in_sof ? 1'b0  : r1_is_b;
    at_last_col = (col_eff == last_col_idx);
    // Asynchronous reads see the old contents at col_eff. The write of in_data
    // to the r-2 memory lands on the clock edge, after these reads.
    prev        = r1_is_b_eff ? mem_b[col_eff] : mem_a[col_eff];
    prev2       = r1_is_b_eff ? mem_a[col_eff] : mem_b[col_eff];
`ifdef LINE_WINDOW_ZERO_PAD_EN
    emit        = 1'b1;
    top_d       = (rows_eff == 2'd2) ? prev2 : '0;
    mid_d       = (rows_eff != 2'd0) ? prev  : '0;
`else
    emit        = (rows_eff == 2'd2);
    top_d       = prev2;
    mid_d       = prev;
`endif
  end

  // Memory contents are never reset. Stale data is masked by rows_seen.
  always_ff @(posedge clk) begin
    if (accept && !r1_is_b_eff) mem_b[col_eff] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (accept && r1_is_b_eff) mem_a[col_eff] <= in_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      col       <= '0;
      rows_seen <= 2'd0;
      r1_is_b   <= 1'b0;
    end else if (accept) begin
      if (at_last_col) begin
        // The row just written (r-2 memory) becomes r-1 for the next row.
        col       <= '0;
        r1_is_b   <= !r1_is_b_eff;
        rows_seen <= (rows_eff == 2'd2) ? 2'd2 : rows_eff + 2'd1;
      end else begin
        col       <= col_eff + col_bits'(1);
        r1_is_b   <= r1_is_b_eff;
        rows_seen <= rows_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_top   <= '0;
      out_mid   <= '0;
      out_bot   <= '0;
      out_last  <= 1'b0;
    end else if (accept && emit) begin
      out_valid <= 1'b1;
      out_top   <= top_d;
      out_mid   <= mid_d;
      out_bot   <= in_data;
      out_last  <= at_last_col;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_line_window_3row.sv
`timescale 1ns/1ps
// tb_line_window_3row: directed stimulus with a queue scoreboard of expected
//   window columns, derived from image coordinates (value = base + row*16 + col).
// Columns are popped and compared as they transfer at the output.

module tb_line_window_3row;

  localparam int IW = 20;
  localparam int LW = 4;
`ifdef LINE_WINDOW_ZERO_PAD_EN
  localparam bit ZP = 1'b1;
`else
  localparam bit ZP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          in_sof = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [IW-1:0] out_top, out_mid, out_bot;
  logic          out_last;

  line_window_3row #(.int_bits(IW), .line_width(LW)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_sof(in_sof), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_top(out_top), .out_mid(out_mid), .out_bot(out_bot), .out_last(out_last)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  int n_out  = 0;
  logic [3*IW:0] exp_q [$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [IW-1:0] pix(input int base, input int r, input int c);
    return IW'(base + r * 16 + c);
  endfunction

  // Scoreboard: compare every transferred column against the queue head.
  always @(negedge clk) begin
    if (reset && out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        check("unexpected_output", 64'd1, 64'd0);
      end else begin
        logic [3*IW:0] e;
        e = exp_q.pop_front();
        check("out_top",  64'(out_top),  64'(e[3*IW:2*IW+1]));
        check("out_mid",  64'(out_mid),  64'(e[2*IW:IW+1]));
        check("out_bot",  64'(out_bot),  64'(e[IW:1]));
        check("out_last", 64'(out_last), 64'(e[0]));
      end
    end
  end

  // Drive one sample and push the column it should produce, if any.
  task automatic present(input int base, input int r, input int c, input bit sof);
    logic [IW-1:0] t, m;
    t = (r >= 2) ? pix(base, r - 2, c) : '0;
    m = (r >= 1) ? pix(base, r - 1, c) : '0;
    if (ZP || r >= 2) exp_q.push_back({t, m, pix(base, r, c), (c == LW - 1)});
    in_valid = 1'b1;
    in_sof   = sof;
    in_data  = pix(base, r, c);
  endtask

  task automatic wait_accept();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    if (!ok) check("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_rows(input int base, input int rows);
    for (int r = 0; r < rows; r++)
      for (int c = 0; c < LW; c++) begin
        present(base, r, c, (r == 0 && c == 0));
        wait_accept();
      end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic drain(input string tag);
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check(tag, 64'(exp_q.size()), 64'd0);
  endtask

  int n0;

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_top",   64'(out_top),   64'd0);
    check("rst_out_mid",   64'(out_mid),   64'd0);
    check("rst_out_bot",   64'(out_bot),   64'd0);
    check("rst_out_last",  64'(out_last),  64'd0);
    check("rst_in_ready",  64'(in_ready),  64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Scenario 1: rows 0..2
    n0 = n_out;
    send_rows(0, 3);
    drain("s1_queue_empty");
    check("s1_count", 64'(n_out - n0), ZP ? 64'd12 : 64'd4);

    // Scenario 2: rows 0..3, exercises the second role swap
    n0 = n_out;
    send_rows(0, 4);
    drain("s2_queue_empty");
    check("s2_count", 64'(n_out - n0), ZP ? 64'd16 : 64'd8);

    // Scenario 3: stall at row 2 col 0 with the next sample already offered
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < LW; c++) begin
        present(0, r, c, (r == 0 && c == 0));
        wait_accept();
      end
    present(0, 2, 0, 1'b0);
    wait_accept();
    out_ready = 1'b0;
    present(0, 2, 1, 1'b0);
    repeat (5) begin
      @(negedge clk);
      check("stall_in_ready",  64'(in_ready),  64'd0);
      check("stall_out_valid", 64'(out_valid), 64'd1);
      check("stall_top",       64'(out_top),   64'd0);
      check("stall_mid",       64'(out_mid),   64'd16);
      check("stall_bot",       64'(out_bot),   64'd32);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_accept();
    for (int c = 2; c < LW; c++) begin
      present(0, 2, c, 1'b0);
      wait_accept();
    end
    drain("s3_queue_empty");

    // Scenario 4: new frame starts at old row 2 col 2
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LW; c++) begin
        if (r == 2 && c == 2) break;
        present(0, r, c, (r == 0 && c == 0));
        wait_accept();
      end
    n0 = n_out;
    send_rows(200, 3);
    drain("s4_queue_empty");
    check("s4_new_frame_count", 64'(n_out - n0), ZP ? 64'd13 : 64'd5);

    // Scenario 5: reset while a column is held in the output register
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < LW; c++) begin
        if (r == 2 && c == 2) break;
        present(0, r, c, (r == 0 && c == 0));
        wait_accept();
      end
    in_valid = 1'b0;
    check("pre_reset_valid", 64'(out_valid), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(out_valid), 64'd0);
    check("mid_rst_out_top",   64'(out_top),   64'd0);
    check("mid_rst_out_mid",   64'(out_mid),   64'd0);
    check("mid_rst_out_bot",   64'(out_bot),   64'd0);
    check("mid_rst_out_last",  64'(out_last),  64'd0);
    if (exp_q.size() != 0) void'(exp_q.pop_back());
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    n0 = n_out;
    send_rows(0, 3);
    drain("s5_queue_empty");
    check("s5_count", 64'(n_out - n0), ZP ? 64'd12 : 64'd4);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule

// File: doc/line_window_3row.md
# line_window_3row

- Streaming 3-row line buffer that sits directly upstream of `line_buffer_unit`.
- Accepts one `int_bits`-wide integer sample per handshake in raster order.
- Stores the two previous image rows in on-chip row memories.
- Emits a vertically aligned 3-tap column: row r-2, row r-1 and row r at the current column. These taps drive `line_buffer_unit`'s `in[0..2]` before FP8 conversion.

## Interface
Parameters:
- `int_bits`, 20, sample width in bits.
- `line_width`, 64, samples per image row (≥2).
- `col_bits`, `$clog2(line_width)`, column counter width.

Ports:
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `in_valid` input 1: input sample valid.
- `in_ready` output 1: block can accept a sample.
- `in_sof` input 1: start of frame, qualified by the input handshake.
- `in_data` input `int_bits`: input sample.
- `out_valid` output 1: window column valid.
- `out_ready` input 1: downstream accepts the column.
- `out_top` output `int_bits`: sample from row r-2, same column.
- `out_mid` output `int_bits`: sample from row r-1, same column.
- `out_bot` output `int_bits`: current sample, row r.
- `out_last` output 1: column is `line_width-1`.

## Operation
Handshakes:
- Input accept = `in_valid && in_ready`.
- Output transfer = `out_valid && out_ready`.
- `in_ready = !out_valid || out_ready`. The block uses a single output register and no skid buffer.

Row memories:
- Two memories, A and B, each `line_width` × `int_bits`.
- Roles ping-pong each row: one holds r-1, the other r-2.
- On accept at column `col`:
  - Read `prev = mem_r1[col]` and `prev2 = mem_r2[col]`.
  - Write `in_data` into the r-2 memory at `col`. Its old content has already been read, so read-before-write ordering is required at the same address.
- On the accept of column `line_width-1`, swap memory roles.

Counters:
- `col` increments per accept and wraps from `line_width-1` to 0.
- `rows_seen` (2 bits) increments on each column wrap and saturates at 2.

Start of frame:
- An accept with `in_sof=1` forces that sample to column 0 and sets `rows_seen=0` before use.
- Any partial row is discarded and the memory roles reset.

Window emission:
- When `rows_seen==2` at accept: load `out_top=prev2`, `out_mid=prev`, `out_bot=in_data`, `out_last=(col==line_width-1)`, and set `out_valid=1`.
- When `rows_seen<2`: store the sample only; no output is produced (see Configuration).
- After an output transfer with no new load that cycle, `out_valid` clears.

Memory contents are never reset; only counters and outputs are.

## Timing
- Reset values: `out_valid=0`, `out_top=out_mid=out_bot=0`, `out_last=0`, `col=0`, `rows_seen=0`, memory roles at default. `in_ready` is 1 after reset.
- Latency: one cycle from input accept to `out_valid`/data.
- Throughput: one sample per cycle when `out_ready` stays high.
- Simultaneous output transfer and input accept in the same cycle: the register reloads and `out_valid` stays 1.
- Backpressure:
  - While `out_valid && !out_ready`, outputs hold stable and `in_ready=0`.
  - The counters and memories do not change.
- Column wrap and swap: take effect on the same edge as the last-column accept. The next sample reads the swapped memories.
- `reset` asserted mid-frame: all state returns to reset values asynchronously. The next frame must begin with `in_sof`.

## Configuration
- `LINE_WINDOW_ZERO_PAD_EN` defined:
  - Every accepted sample produces an output column.
  - Taps referring to rows not yet seen read as 0, masked by `rows_seen`, not by memory contents.
  - Row 0 gives `top=mid=0`.
  - Row 1 gives `top=0`, `mid=`row0.
- Not defined: rows 0 and 1 of each frame produce no output. The output count per frame is `(rows-2)*line_width`.

## Test plan
All scenarios use `line_width=4`, `int_bits=20`, and sample value `row*16+col`. First sample of each frame carries `in_sof`.
- Reset then stream rows 0–2 with `out_ready=1`, zero-pad off → no output during rows 0–1; the row-2 col-1 output is top=1, mid=17, bot=33, `out_last=0`; col 3 gives 3/19/35 with `out_last=1`.
- Stream rows 0–3 continuously → row-3 col-0 output is 16/32/48, confirming the role swap; exactly 8 outputs total.
- Hold `out_ready=0` for 5 cycles at the row-2 col-0 output → `in_ready=0`, outputs hold 0/16/32, and no samples are lost after release.
- `in_sof` at row 2 col 2, then a new frame of 3 rows → no output until new-frame row 2; values come from the new frame only.
- Assert `reset` low while `out_valid=1` → outputs and `out_valid` go to 0 immediately; the following frame behaves as in the first scenario.
- With `LINE_WINDOW_ZERO_PAD_EN` → row 0 col 2 outputs 0/0/2; row 1 col 2 outputs 0/2/18; 12 outputs for 3 rows.
